// File: rtl/if_id_stage.sv
// if_id_stage: program counter, instruction fetch and the IF/ID pipeline register.
// Latency: an instruction fetched at imem_addr appears on id_inst one cycle later; id_pc4, id_imm_field and imem_addr are combinational.
// Backpressure: stall freezes PC and IF/ID, flush and redirect insert bubbles, and a misaligned redirect halts fetch until an aligned redirect arrives.
//
// Ports:
//   clk, rst_n             clock and async active-low reset
//   stall, flush           hazard hold / bubble insert (ignored in HALT)
//   redirect_en/_pc        taken branch or jump target
//   imem_addr/imem_rdata   instruction memory address (== PC) and combinational read data
//   id_pc/id_pc4/id_inst   IF/ID register contents plus derived PC+4
//   id_imm_field           id_inst[31:7] for the immediate extender
//   id_valid               id_inst is a real instruction
//   misalign               sticky instruction-address-misaligned flag
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic [24:0] id_imm_field,
  output logic        id_valid,
  output logic        misalign
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic        redir_aligned;
  logic [31:0] pc_plus4;

  assign redir_aligned = (redirect_pc[1:0] == 2'b00);
  // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
  assign pc_plus4      = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    misalign_d = misalign_q;

    case (state_q)
      RUN: begin
        if (redirect_en) begin
          id_pc_d    = pc_q;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
          if (redir_aligned) begin
            pc_d = redirect_pc;
          end else begin
            // PC holds so the faulting fetch context is preserved for debug.
            misalign_d = 1'b1;
            state_d    = HALT;
          end
        end else if (flush) begin
          id_pc_d    = pc_q;
          id_inst_d  = NOP_INST;
          id_valid_d = 1'b0;
          if (!stall) begin
            pc_d = pc_plus4;
          end
        end else if (!stall) begin
          pc_d       = pc_plus4;
          id_pc_d    = pc_q;
          id_inst_d  = imem_rdata;
          id_valid_d = 1'b1;
        end
      end

      HALT: begin
        // Keep the bubble in ID; only an aligned redirect restarts fetch.
        id_pc_d    = pc_q;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
        if (redirect_en && redir_aligned) begin
          pc_d       = redirect_pc;
          misalign_d = 1'b0;
          state_d    = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      id_pc_q    <= RESET_PC;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr    = pc_q;
  assign id_pc        = id_pc_q;
  assign id_pc4       = id_pc_q + 32'd4;
  assign id_inst      = id_inst_q;
  assign id_imm_field = id_inst_q[31:7];
  assign id_valid     = id_valid_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed vector table, hand-written reset/wrap
// sequences and randomized traffic checked against a behavioural model.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic [24:0] id_imm_field;
  logic        id_valid;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_pc        (id_pc),
    .id_pc4       (id_pc4),
    .id_inst      (id_inst),
    .id_imm_field (id_imm_field),
    .id_valid     (id_valid),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: fixed word at address 0, address hash elsewhere.
  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0017;
  endfunction

  assign imem_rdata = imem_fn(imem_addr);

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  logic        m_valid, m_mis, m_halted;

  task automatic model_reset();
    m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP;
    m_valid = 1'b0; m_mis = 1'b0; m_halted = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":imem_addr"}, imem_addr, m_pc);
    chk({tag, ":id_pc"},     id_pc, m_id_pc);
    chk({tag, ":id_pc4"},    id_pc4, m_id_pc + 32'd4);
    chk({tag, ":id_inst"},   id_inst, m_id_inst);
    chk({tag, ":id_imm"},    {7'd0, id_imm_field}, {7'd0, m_id_inst[31:7]});
    chk({tag, ":id_valid"},  {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ":misalign"},  {31'd0, misalign}, {31'd0, m_mis});
  endtask

  // One clock: model computes next state from the inputs applied now,
  // DUT is sampled at the following falling edge.
  task automatic tick(input string tag);
    logic [31:0] n_pc, n_id_pc, n_inst;
    logic        n_valid, n_mis, n_halt;
    logic        aligned;
    aligned = (redirect_pc[1:0] == 2'b00);
    n_pc = m_pc; n_id_pc = m_id_pc; n_inst = m_id_inst;
    n_valid = m_valid; n_mis = m_mis; n_halt = m_halted;
    if (m_halted) begin
      n_id_pc = m_pc; n_inst = NOP; n_valid = 1'b0;
      if (redirect_en && aligned) begin
        n_pc = redirect_pc; n_mis = 1'b0; n_halt = 1'b0;
      end
    end else if (redirect_en) begin
      n_id_pc = m_pc; n_inst = NOP; n_valid = 1'b0;
      if (aligned) n_pc = redirect_pc;
      else begin n_mis = 1'b1; n_halt = 1'b1; end
    end else if (flush) begin
      n_id_pc = m_pc; n_inst = NOP; n_valid = 1'b0;
      if (!stall) n_pc = m_pc + 32'd4;
    end else if (!stall) begin
      n_id_pc = m_pc; n_inst = imem_fn(m_pc); n_valid = 1'b1;
      n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    m_pc = n_pc; m_id_pc = n_id_pc; m_id_inst = n_inst;
    m_valid = n_valid; m_mis = n_mis; m_halted = n_halt;
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp);
    stall = s; flush = f; redirect_en = r; redirect_pc = rp;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        s, f, r;
    logic [31:0] rp;
    logic [31:0] e_addr;
    logic [31:0] e_id_pc;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h4,   32'h0,   1'b1, 1'b0}; // first fetch
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,   1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,   1'b1, 1'b0}; // stall x3 at PC 8
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,   1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h8,   32'h4,   1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'hC,   32'h8,   1'b1, 1'b0}; // fetch from 8 lands
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h10,  32'hC,   1'b0, 1'b0}; // flush, PC advances
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h10,  32'h10,  1'b0, 1'b0}; // flush + stall, PC holds
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h100, 32'h10,  1'b0, 1'b0}; // redirect beats stall
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'h100, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h102, 32'h104, 32'h104, 1'b0, 1'b1}; // misaligned -> HALT
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h104, 32'h104, 1'b0, 1'b1}; // HALT holds
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h103, 32'h104, 32'h104, 1'b0, 1'b1}; // misaligned again in HALT
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'h200, 32'h104, 1'b0, 1'b0}; // aligned redirect leaves HALT
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h204, 32'h200, 1'b1, 1'b0}; // fetch from 0x200
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h200, 32'h200, 32'h204, 1'b0, 1'b0}; // redirect beats both
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].r, tbl[i].rp);
      tick($sformatf("vec%0d", i));
      chk($sformatf("vec%0d:addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d:id_pc", i), id_pc, tbl[i].e_id_pc);
      chk($sformatf("vec%0d:valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d:mis", i), {31'd0, misalign}, {31'd0, tbl[i].e_mis});
      chk($sformatf("vec%0d:inst", i), id_inst,
          tbl[i].e_valid ? imem_fn(tbl[i].e_id_pc) : NOP);
    end

    // PC wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick("wrap_redir");
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick("wrap_adv");
    chk("wrap:addr", imem_addr, 32'h0);
    chk("wrap:id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap:id_pc4", id_pc4, 32'h0);

    // Async reset between edges while id_valid=1
    chk("pre_rst:valid", {31'd0, id_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst:addr", imem_addr, 32'h4);
    chk("post_rst:inst", id_inst, 32'h0050_0093);

    // Reset while halted and stalled
    drive(1'b0, 1'b0, 1'b1, 32'h33);
    tick("halt_enter");
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick("halt_stall");
    chk("halt:mis", {31'd0, misalign}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("halt_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick("halt_rst_adv");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = $urandom;
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
      if ($urandom_range(7) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hC);
      drive($urandom_range(9) < 3, $urandom_range(9) < 2, $urandom_range(9) == 0, rp);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port stall, input, 1 bit: hazard hold; freezes PC and the IF/ID register.
REQ-006 The block SHALL have port flush, input, 1 bit: inserts a bubble into the IF/ID register.
REQ-007 The block SHALL have port redirect_en, input, 1 bit: a taken branch or jump loads redirect_pc.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: the branch or jump target.
REQ-009 The block SHALL have port imem_addr, output, 32 bits: instruction memory address, equal to the current PC.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: instruction word, combinational read of imem_addr.
REQ-011 The block SHALL have port id_pc, output, 32 bits: PC of the instruction held in ID.
REQ-012 The block SHALL have port id_pc4, output, 32 bits: id_pc + 4.
REQ-013 The block SHALL have port id_inst, output, 32 bits: instruction held in ID.
REQ-014 The block SHALL have port id_imm_field, output, 25 bits: id_inst[31:7], the field consumed by the immediate extender.
REQ-015 The block SHALL have port id_valid, output, 1 bit: id_inst is a real instruction, not a bubble.
REQ-016 The block SHALL have port misalign, output, 1 bit: sticky instruction-address-misaligned flag.

Function
REQ-017 The block SHALL have a two-state FSM: RUN and HALT.
REQ-018 In RUN, the block SHALL apply this per-cycle priority: redirect_en, then flush, then stall, then normal advance.
REQ-019 On normal advance, the block SHALL set PC <= PC+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and load the IF/ID register: id_pc<=PC, id_inst<=imem_rdata, id_valid<=1.
REQ-020 When stall is high with no redirect_en and no flush, PC and the IF/ID register SHALL hold their values unchanged.
REQ-021 When flush is high with no redirect_en, the IF/ID register SHALL load the bubble (id_inst<=NOP_INST, id_valid<=0, id_pc<=PC), and PC SHALL advance if stall is low, otherwise hold.
REQ-022 When redirect_en is high and redirect_pc[1:0]==0, the block SHALL set PC<=redirect_pc and load the bubble into IF/ID, regardless of stall and flush.
REQ-023 When redirect_en is high and redirect_pc[1:0]!=0, the block SHALL set misalign<=1, load the bubble into IF/ID, hold PC, and move to HALT.
REQ-024 In HALT, id_valid SHALL stay 0, id_inst SHALL stay NOP_INST, and PC SHALL stay frozen; stall and flush SHALL be ignored.
REQ-025 In HALT, an aligned redirect_en SHALL load PC<=redirect_pc, clear misalign, and return to RUN; a misaligned redirect SHALL keep the state in HALT.
REQ-026 id_pc4 and id_imm_field SHALL be combinational from the registered values, with no added latency.
REQ-027 imem_addr SHALL equal the PC register combinationally.
REQ-028 Instruction latency from imem_addr to id_inst SHALL be exactly 1 cycle when no stall, flush or redirect is active.

Reset
REQ-029 While rst_n is low, asynchronously and independent of clk, the block SHALL force PC=RESET_PC, id_pc=RESET_PC, id_inst=NOP_INST, id_valid=0, misalign=0, FSM=RUN.
REQ-030 The first rising edge after rst_n deasserts SHALL perform a normal advance (the REQ-018 priority applies).
REQ-031 Reset asserted mid-stall or while in HALT SHALL override all other inputs immediately.

Verification
REQ-032 Verification SHALL cover this scenario: reset release, imem returns 32'h00500093 at PC 0 -> next cycle id_pc=0, id_inst=32'h00500093, id_valid=1, imem_addr=4.
REQ-033 Verification SHALL cover this scenario: stall held high for 3 cycles at PC=8 -> imem_addr stays 8 and id_* stay unchanged for all 3 cycles; after release, the fetch from 8 reaches ID one cycle later.
REQ-034 Verification SHALL cover this scenario: redirect_en with redirect_pc=32'h100 together with stall=1 -> next cycle PC=32'h100, id_valid=0, id_inst=32'h00000013.
REQ-035 Verification SHALL cover this scenario: redirect_pc=32'h102 -> misalign=1, HALT entered; a later aligned redirect to 32'h200 clears misalign and fetches from 32'h200.
REQ-036 Verification SHALL cover this scenario: PC=32'hFFFF_FFFC with normal advance -> PC wraps to 0, id_pc=32'hFFFF_FFFC, id_pc4=0.
REQ-037 Verification SHALL cover this scenario: rst_n pulsed low between clock edges while id_valid=1 -> outputs take their reset values immediately, before the next clk edge.
